// File: rtl/sd_link_arb_pkg.sv
// sd_link_arb_pkg: shared FSM encoding and channel-id width helper for the link arbiter
package sd_link_arb_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOW = 2'd1, ST_HIGH = 2'd2} state_t;
   function automatic int isz_f(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sd_link_arb_if.sv
// sd_link_arb_if: requester bus plus half-width link bus of the link arbiter
//   c_srdy/c_data/c_drdy : per-channel full-width source handshake (channel k at c_data[k*width +: width])
//   p_srdy/p_data/p_chan/p_last/p_drdy : half-beat link handshake, p_last marks the high half
//   master : arbiter side, slave : requesters plus downstream link
interface sd_link_arb_if #(parameter int width = 8, parameter int inputs = 4);
   import sd_link_arb_pkg::*;
   localparam int isz = isz_f(inputs);
   logic [inputs-1:0]       c_srdy;
   logic [inputs-1:0]       c_drdy;
   logic [inputs*width-1:0] c_data;
   logic                    p_srdy;
   logic                    p_drdy;
   logic                    p_last;
   logic [width/2-1:0]      p_data;
   logic [isz-1:0]          p_chan;
   modport master (input c_srdy, c_data, p_drdy, output c_drdy, p_srdy, p_data, p_chan, p_last);
   modport slave  (output c_srdy, c_data, p_drdy, input c_drdy, p_srdy, p_data, p_chan, p_last);
endinterface

// File: rtl/sd_rr_pick.sv
// sd_rr_pick: combinational round-robin picker, first requester scanning from ptr+1 modulo inputs
//   req    : request vector
//   ptr    : last granted index
//   gnt    : one-hot grant (zero when no request)
//   gnt_id : index of the granted requester
//   any    : at least one request present
module sd_rr_pick #(
   parameter int inputs = 4,
   parameter int isz    = 2
) (
   input  logic [inputs-1:0] req,
   input  logic [isz-1:0]    ptr,
   output logic [inputs-1:0] gnt,
   output logic [isz-1:0]    gnt_id,
   output logic              any
);
   always_comb begin
      int k;
      logic [isz-1:0] w_idx;
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      k      = 0;
      w_idx  = '0;
      // scan farthest first so the nearest requester after ptr overwrites and wins
      for (int i = inputs; i >= 1; i--) begin
         k     = (int'(ptr) + i) % inputs;
         w_idx = k[isz-1:0];
         if (req[w_idx]) begin
            gnt        = '0;
            gnt[w_idx] = 1'b1;
            gnt_id     = w_idx;
            any        = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sd_link_arb.sv
// sd_link_arb: round-robin arbiter that serializes full-width words onto a half-width srdy/drdy link
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : sd_link_arb_if.master (requester handshakes in, half-beat link out)
// Optional: define SDLIB_LINK_ARB_PRIO0_EN to make channel 0 strict priority over a
// round-robin among channels 1..inputs-1 (channel-0 grants leave the pointer alone).
module sd_link_arb
   import sd_link_arb_pkg::*;
#(
   parameter int width  = 8,
   parameter int inputs = 4
) (
   input logic           clk,
   input logic           reset,
   sd_link_arb_if.master bus
);
   localparam int isz = isz_f(inputs);

   state_t            r_state;
   state_t            w_next;
   logic [width-1:0]  r_hold;
   logic [isz-1:0]    r_chan;
   logic [isz-1:0]    r_ptr;
   logic [inputs-1:0] w_req;
   logic [inputs-1:0] w_gnt;
   logic [inputs-1:0] w_rr_gnt;
   logic [isz-1:0]    w_gnt_id;
   logic [isz-1:0]    w_rr_id;
   logic              w_any;
   logic              w_rr_any;
   logic              w_ptr_upd;
   logic              w_arb;
   logic              w_take;

`ifdef SDLIB_LINK_ARB_PRIO0_EN
   assign w_req     = {bus.c_srdy[inputs-1:1], 1'b0};
   assign w_gnt     = bus.c_srdy[0] ? {{(inputs-1){1'b0}}, 1'b1} : w_rr_gnt;
   assign w_gnt_id  = bus.c_srdy[0] ? '0 : w_rr_id;
   assign w_any     = bus.c_srdy[0] | w_rr_any;
   assign w_ptr_upd = ~bus.c_srdy[0];
`else
   assign w_req     = bus.c_srdy;
   assign w_gnt     = w_rr_gnt;
   assign w_gnt_id  = w_rr_id;
   assign w_any     = w_rr_any;
   assign w_ptr_upd = 1'b1;
`endif

   sd_rr_pick #(.inputs(inputs), .isz(isz)) u_pick (
      .req    (w_req),
      .ptr    (r_ptr),
      .gnt    (w_rr_gnt),
      .gnt_id (w_rr_id),
      .any    (w_rr_any)
   );

   always_comb begin
      // arbitration happens in IDLE or when the high half leaves; held off while in reset
      w_arb       = reset && (r_state == ST_IDLE || (r_state == ST_HIGH && bus.p_drdy));
      w_take      = w_arb && w_any;
      w_next      = w_take ? ST_LOW :
                    (r_state == ST_LOW) ? (bus.p_drdy ? ST_HIGH : ST_LOW) :
                    (r_state == ST_HIGH && !bus.p_drdy) ? ST_HIGH : ST_IDLE;
      bus.c_drdy  = w_take ? w_gnt : '0;
      bus.p_srdy  = r_state != ST_IDLE;
      bus.p_last  = r_state == ST_HIGH;
      bus.p_data  = (r_state == ST_HIGH) ? r_hold[width-1:width/2] : r_hold[width/2-1:0];
      bus.p_chan  = r_chan;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_hold <= '0;
         r_chan <= '0;
         r_ptr  <= isz'(inputs - 1);
      end else if (w_take) begin
         r_hold <= bus.c_data[w_gnt_id*width +: width];
         r_chan <= w_gnt_id;
         if (w_ptr_upd) r_ptr <= w_gnt_id;
      end
endmodule

// File: tb/tb_sd_link_arb.sv
// tb_sd_link_arb: scoreboard bench for sd_link_arb, words pushed on accept and checked per half-beat
module tb_sd_link_arb;
   localparam int W = 8;
   localparam int N = 4;

   typedef struct packed {
      logic [1:0]   ch;
      logic [W-1:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sd_link_arb_if #(.width(W), .inputs(N)) bus ();
   sd_link_arb #(.width(W), .inputs(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;
   int words = 0;
   logic [W-1:0] src_q [N][$];
   exp_t exp_q[$];
   int ord_q[$];
   logic [N-1:0] en = '0;
   logic pd = 1'b1;
   bit rnd = 1'b0;
   logic mon_hi = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.c_drdy === '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.c_drdy === '0) begin
         checks++;
         failures++;
         $display("FAIL %s: no grant within 50 cycles", name);
      end
   endtask

   function automatic bit idle_now();
      bit e;
      e = exp_q.size() == 0 && !bus.p_srdy;
      for (int k = 0; k < N; k++) if (src_q[k].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic wait_idle(input string name, input int lim);
      int n;
      n = 0;
      @(negedge clk);
      while (!idle_now() && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (!idle_now()) begin
         checks++;
         failures++;
         $display("FAIL %s: not drained within %0d cycles", name, lim);
      end
   endtask

   // driver: records accepted words into the scoreboard, then refreshes the sources after the edge
   initial begin
      bit on;
      exp_t e;
      bus.c_srdy = '0;
      bus.c_data = '0;
      bus.p_drdy = 1'b1;
      forever begin
         @(negedge clk);
         if (reset)
            for (int k = 0; k < N; k++)
               if (bus.c_srdy[k] && bus.c_drdy[k] && src_q[k].size() != 0) begin
                  e.ch = 2'(k);
                  e.d  = src_q[k][0];
                  exp_q.push_back(e);
                  void'(src_q[k].pop_front());
               end
         if (bus.c_drdy != '0) begin
            chk("drdy_onehot", $countones(bus.c_drdy), 1);
            chk("drdy_without_srdy", bus.c_drdy & ~bus.c_srdy, 0);
         end
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            on = rnd ? ($urandom_range(9, 0) < 7) : en[k];
            bus.c_srdy[k] = on && src_q[k].size() != 0;
            bus.c_data[k*W +: W] = (src_q[k].size() != 0) ? src_q[k][0] : '0;
         end
         bus.p_drdy = rnd ? ($urandom_range(9, 0) < 7) : pd;
      end
   end

   // monitor: pops the scoreboard on every link transfer
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            mon_hi = 1'b0;
            exp_q.delete();
         end else if (bus.p_srdy && bus.p_drdy) begin
            chk("p_last", bus.p_last, mon_hi);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got data %0h chan %0d, expected no transfer", bus.p_data, bus.p_chan);
            end else begin
               chk("p_chan", bus.p_chan, exp_q[0].ch);
               chk("p_data", bus.p_data, mon_hi ? exp_q[0].d[W-1:W/2] : exp_q[0].d[W/2-1:0]);
               if (!mon_hi && ord_q.size() != 0) chk("grant_order", bus.p_chan, ord_q.pop_front());
               if (mon_hi) begin
                  void'(exp_q.pop_front());
                  words++;
               end
            end
            mon_hi = ~mon_hi;
         end
      end
   end

   initial begin
      int w0;
      repeat (3) @(negedge clk);
      chk("rst_p_srdy", bus.p_srdy, 0);
      chk("rst_p_last", bus.p_last, 0);
      chk("rst_p_chan", bus.p_chan, 0);
      chk("rst_p_data", bus.p_data, 0);
      chk("rst_c_drdy", bus.c_drdy, 0);
      @(posedge clk);
      #3 reset = 1'b1;

      // all channels, two words each, continuous link
      for (int k = 0; k < N; k++)
         for (int i = 0; i < 2; i++) src_q[k].push_back(8'(8'h11 * (k + 1) + 8'h40 * i));
`ifdef SDLIB_LINK_ARB_PRIO0_EN
      ord_q = {0, 0, 1, 2, 3, 1, 2, 3};
`else
      ord_q = {0, 1, 2, 3, 0, 1, 2, 3};
`endif
      en = '1;
      wait_grant("all_first");
      chk("all_first_gnt", bus.c_drdy, 4'b0001);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("no_bubble", bus.p_srdy, 1);
      end
      wait_idle("all_drain", 100);
      chk("all_order_left", ord_q.size(), 0);

      // single channel 2
      en = 4'b0100;
      src_q[2].push_back(8'hC3);
      wait_grant("single");
      chk("single_gnt", bus.c_drdy, 4'b0100);
      @(negedge clk);
      chk("single_gnt_once", bus.c_drdy, 0);
      chk("single_lo_data", bus.p_data, 4'h3);
      chk("single_lo_last", bus.p_last, 0);
      chk("single_lo_chan", bus.p_chan, 2);
      @(negedge clk);
      chk("single_hi_data", bus.p_data, 4'hC);
      chk("single_hi_last", bus.p_last, 1);
      chk("single_hi_chan", bus.p_chan, 2);
      wait_idle("single_drain", 50);

      // backpressure in LOW with a second requester waiting (pointer at 2, so 3 then 1)
      pd = 1'b0;
      src_q[3].push_back(8'hA5);
      src_q[1].push_back(8'h5A);
      ord_q = {3, 1};
      en = 4'b1010;
      wait_grant("bp");
      chk("bp_gnt", bus.c_drdy, 4'b1000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_srdy", bus.p_srdy, 1);
         chk("bp_data", bus.p_data, 4'h5);
         chk("bp_last", bus.p_last, 0);
         chk("bp_chan", bus.p_chan, 3);
         chk("bp_drdy", bus.c_drdy, 0);
      end
      pd = 1'b1;
      wait_idle("bp_drain", 50);
      chk("bp_order_left", ord_q.size(), 0);

      // async reset while in HIGH, then restart with pointer back at inputs-1
      en = 4'b0010;
      src_q[1].push_back(8'h77);
      ord_q = {1};
      wait_grant("rst_mid");
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("pre_rst_high", bus.p_last, 1);
      reset = 1'b0;
      #1;
      chk("rst_mid_p_srdy", bus.p_srdy, 0);
      chk("rst_mid_p_last", bus.p_last, 0);
      src_q[0].push_back(8'h99);
      src_q[2].push_back(8'h66);
      en = 4'b0101;
      repeat (3) @(negedge clk);
      chk("rst_hold_c_drdy", bus.c_drdy, 0);
      ord_q = {0, 2};
      @(posedge clk);
      #3 reset = 1'b1;
      wait_grant("post_rst");
      chk("post_rst_gnt", bus.c_drdy, 4'b0001);
      wait_idle("post_rst_drain", 50);
      chk("post_rst_order_left", ord_q.size(), 0);

      // channels 0 and 3 requesting continuously, channel 0 runs dry first
      for (int i = 0; i < 4; i++) src_q[0].push_back(8'(8'h20 + i));
      for (int i = 0; i < 2; i++) src_q[3].push_back(8'(8'hE0 + i));
`ifdef SDLIB_LINK_ARB_PRIO0_EN
      ord_q = {0, 0, 0, 0, 3, 3};
`else
      ord_q = {3, 0, 3, 0, 0, 0};
`endif
      en = 4'b1001;
      wait_idle("pair_drain", 100);
      chk("pair_order_left", ord_q.size(), 0);

      // random srdy/drdy traffic
      w0 = words;
      for (int k = 0; k < N; k++)
         for (int i = 0; i < 300; i++) src_q[k].push_back(8'($urandom));
      rnd = 1'b1;
      wait_idle("rand_drain", 20000);
      rnd = 1'b0;
      chk("rand_words", words - w0, 1200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sd_link_arb.md
Name: sd_link_arb

Overview:
- Round-robin arbiter and serializer that shares one half-width srdy/drdy link between `inputs` full-width requesters.
- Each granted word is sent as two half-beats, low half first, tagged with the source channel. `p_last` marks the second half.
- Sits upstream of the half-width link: replaces the single-source enmux front end so several generators share one narrow channel.
- The far-end demux/steering logic reconstructs words using `p_chan` and `p_last`.

Parameters:
- width, 8, full word width; must be even, >=2
- inputs, 4, number of requesting channels, >=2
- isz (localparam), max($clog2(inputs),1), channel id width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low: state clears immediately while reset==0
- c_srdy  in  inputs  per-channel source ready
- c_data  in  inputs*width  channel k occupies bits [k*width +: width]
- c_drdy  out  inputs  per-channel accept, one-hot or zero
- p_srdy  out  1  half-beat valid
- p_data  out  width/2  current half-beat
- p_chan  out  isz  channel that owns the word in flight
- p_last  out  1  1 on the high half-beat
- p_drdy  in  1  downstream accept

Behaviour:
- Handshakes: a transfer occurs on a rising edge where srdy&drdy==1. Data is held stable while srdy=1 and drdy=0.
- Reset values: p_srdy=0, p_last=0, p_chan=0, p_data=0, c_drdy=0. State=IDLE, hold register=0, rr pointer=inputs-1 so channel 0 has first priority.
- State machine has three states: IDLE, LOW, HIGH.
- IDLE:
  - p_srdy=0.
  - If any c_srdy, winner g = first requesting channel scanning from ptr+1 modulo inputs.
  - c_drdy[g]=1 combinationally. On the edge: hold<=c_data[g], chan<=g, ptr<=g, state<=LOW.
- LOW:
  - p_srdy=1, p_data=hold[width/2-1:0], p_last=0, c_drdy=0.
  - On p_drdy the state goes to HIGH.
- HIGH:
  - p_srdy=1, p_data=hold[width-1:width/2], p_last=1.
  - If p_drdy and a requester exists: c_drdy[winner]=1 in the same cycle, capture as in IDLE, go to LOW (back-to-back, no bubble).
  - If p_drdy and no request: go to IDLE.
  - If !p_drdy: c_drdy=0 and hold, chan and state are unchanged.
- Throughput and latency:
  - Peak throughput is 1 word per 2 cycles.
  - Word accepted at edge N: low half is visible in cycle N+1, high half no earlier than N+2.
- Locking:
  - Grant is locked for both half-beats. Another channel never interleaves with a word in flight.
  - `p_chan` is constant across the LOW/HIGH pair.
- Fairness: a channel that keeps requesting waits at most inputs-1 words.
- A c_srdy that drops before it is accepted is legal. Arbitration is recomputed every cycle that c_drdy may assert.
- Pointer wraps from inputs-1 to 0. With all channels requesting, grant order is 0,1,..,inputs-1,0,...
- Async reset mid-word discards the half-sent word. After release the block restarts in IDLE with pointer at inputs-1.
- Combinational paths: p_drdy->c_drdy and c_srdy->c_drdy are permitted. No combinational path from c_data to p_data (p_data comes from registers only).

Optional Feature:
- Macro: SDLIB_LINK_ARB_PRIO0_EN.
- Defined: channel 0 is strict-priority. Whenever c_srdy[0]=1 at an arbitration point, channel 0 wins regardless of pointer, and the pointer is not updated by channel-0 grants. Channels 1..inputs-1 remain round-robin among themselves.
- Undefined: pure round-robin over all channels, as above.

Decomposition:
- Shared header sd_link_arb_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_LOW=2'd1, ST_HIGH=2'd2
  - macro for the isz computation
- Sub-module sd_rr_pick is combinational:
  - Inputs: req[inputs-1:0], ptr[isz-1:0].
  - Outputs: gnt one-hot, gnt_id, any.
  - Reusable by other arbiters.
- Top level holds the FSM, hold register and pointer.

Test Plan:
- Single channel: c_srdy[2]=1, c_data[2]=8'hC3, p_drdy=1 -> c_drdy=4'b0100 for one cycle; p_data 4'h3 (p_last=0) then 4'hC (p_last=1), p_chan=2 on both.
- All four channels request continuously with p_drdy=1 -> grant order 0,1,2,3,0; one half-beat every cycle with no bubble between words.
- Backpressure: p_drdy held 0 for 5 cycles during LOW -> p_data, p_chan and p_last stable; c_drdy=0; no second grant.
- Async reset (reset=0) mid-word, in HIGH -> p_srdy drops immediately. After release, first grant goes to channel 0 even if its prior grant was channel 1.
- SDLIB_LINK_ARB_PRIO0_EN defined, channels 0 and 3 requesting continuously -> channel 0 wins every word. Drop c_srdy[0] -> channel 3 granted next.
- Randomized srdy/drdy patterns with a checking receiver that reassembles by p_chan -> per-channel sequences arrive in order, no word split across channels, >=1000 words checked.
